// File: rtl/mem_pkg.sv
// Shared definitions for the single-port memory controller: derived sizes
// and the legal read-latency window of the attached RAM.
package mem_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Response buffer must cover every read the RAM pipeline can hold plus
    // one entry being drained and one being filled in the same cycle.
    function automatic int fifo_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    // One write-enable bit per byte lane, rounding a partial byte up.
    function automatic int be_width(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    function automatic bit rd_latency_legal(input int rd_latency);
        return (rd_latency >= RD_LATENCY_MIN) && (rd_latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/mem_sp_ctrl_if.sv
// Request/response handshake bundle between a requester and mem_sp_ctrl.
interface mem_sp_ctrl_if #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14
);

    logic                                         req_valid;
    logic                                         req_ready;
    logic [mem_pkg::be_width(MEM_DATAWIDTH)-1:0]  req_we;
    logic [MEM_ADDRWIDTH-1:0]                     req_addr;
    logic [MEM_DATAWIDTH-1:0]                     req_wdata;
    logic                                         rsp_valid;
    logic                                         rsp_ready;
    logic [MEM_DATAWIDTH-1:0]                     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_sp_rsp_fifo.sv
// Read-response buffer: small circular FIFO with registered storage.
// Control state is reset; the data array is not.
module mem_sp_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             full;

    // Pointers wrap explicitly since DEPTH is generally not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !do_pop)      count_q <= count_q + 1'b1;
            else if (!push_i && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // Upstream credit accounting must never let a push land on a full buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push_i && full)) else $error("mem_sp_rsp_fifo: push while full");
        end
    end

endmodule

// File: rtl/mem_sp_ctrl.sv
// Single-port RAM controller: forwards accepted requests straight to the RAM,
// tracks reads through the RAM latency, and buffers read data for an
// independently back-pressured response port. Credits guarantee every
// issued read has a buffer slot waiting for it.
module mem_sp_ctrl import mem_pkg::*; #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14,
    parameter int RD_LATENCY    = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    mem_sp_ctrl_if.slave                         bus,
    output logic                                 mem_en,
    output logic [be_width(MEM_DATAWIDTH)-1:0]   mem_we,
    output logic [MEM_ADDRWIDTH-1:0]             mem_addr,
    output logic [MEM_DATAWIDTH-1:0]             mem_din,
    input  logic [MEM_DATAWIDTH-1:0]             mem_dout
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_rd_latency
        $error("mem_sp_ctrl: RD_LATENCY must be within 1..4");
    end

    logic                  accept, rd_accept;
    logic [RD_LATENCY-1:0] rd_sr_q, rd_sr_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic                  fifo_push, fifo_pop, fifo_empty;

    // Occupancy counts every read already owed a buffer slot.
    assign occupancy     = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign bus.req_ready = !reset && (occupancy < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_accept     = accept && (bus.req_we == '0);

    // RAM port is a direct pass-through of the accepted request.
    assign mem_en   = accept;
    assign mem_we   = accept ? bus.req_we : '0;
    assign mem_addr = bus.req_addr;
    assign mem_din  = bus.req_wdata;

    // The bit leaving the tracker marks the cycle mem_dout carries read data.
    assign fifo_push     = rd_sr_q[RD_LATENCY-1];
    assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_valid = !fifo_empty;

    // Next state for the read tracker and the in-flight counter.
    always_comb begin
        rd_sr_d    = rd_sr_q << 1;
        rd_sr_d[0] = rd_accept;
        inflight_d = inflight_q + CNT_W'(rd_accept) - CNT_W'(fifo_push);
    end

    // Read tracker state; reset discards every read still in the RAM pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sr_q    <= '0;
            inflight_q <= '0;
        end else begin
            rd_sr_q    <= rd_sr_d;
            inflight_q <= inflight_d;
        end
    end

    mem_sp_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MEM_DATAWIDTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (mem_dout),
        .pop_i   (fifo_pop),
        .dout_o  (bus.rsp_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: doc/mem_sp_ctrl.md
MEM_SP_CTRL -- requirements
Module: mem_sp_ctrl

Interface
REQ-001 SHALL have parameter MEM_DATAWIDTH, default 128, data width in bits, shared with the attached single-port RAM.
REQ-002 SHALL have parameter MEM_ADDRWIDTH, default 14, word address width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, RAM read latency in cycles; legal range 1..4.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have req_valid  input  1  request present.
REQ-007 SHALL have req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have req_we  input  (MEM_DATAWIDTH+7)/8  byte write mask; all-zero = read.
REQ-009 SHALL have req_addr  input  MEM_ADDRWIDTH  word address.
REQ-010 SHALL have req_wdata  input  MEM_DATAWIDTH  write data.
REQ-011 SHALL have rsp_valid  output  1  read response present.
REQ-012 SHALL have rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have rsp_rdata  output  MEM_DATAWIDTH  read data.
REQ-014 SHALL have mem_en, mem_we, mem_addr, mem_din  outputs  1, (MEM_DATAWIDTH+7)/8, MEM_ADDRWIDTH, MEM_DATAWIDTH  drive the RAM's en/we/addr/din.
REQ-015 SHALL have mem_dout  input  MEM_DATAWIDTH  RAM read data.

Function
REQ-016 SHALL define FIFO_DEPTH = RD_LATENCY+2 response-buffer entries.
REQ-017 SHALL hold inflight = count of accepted reads whose data has not yet entered the response FIFO; occupancy = inflight + FIFO count.
REQ-018 SHALL drive req_ready = (occupancy < FIFO_DEPTH) and not in reset, independent of req_valid and req_we.
REQ-019 SHALL drive mem_en = req_valid & req_ready combinationally, zero added latency; mem_we = req_we when accepted, else 0; mem_addr/mem_din = req_addr/req_wdata.
REQ-020 SHALL classify an accepted request as a write if req_we != 0 (no response generated) and as a read otherwise.
REQ-021 SHALL track reads through an RD_LATENCY-deep valid shift register; the bit leaving it captures mem_dout into the FIFO at the end of that cycle.
REQ-022 SHALL give accept-to-rsp_valid latency of exactly RD_LATENCY+1 cycles when the FIFO is empty.
REQ-023 SHALL drive rsp_valid = FIFO not empty, rsp_rdata = FIFO head; both stable while rsp_valid & !rsp_ready.
REQ-024 SHALL return responses strictly in request order.
REQ-025 SHALL leave FIFO count unchanged on simultaneous push and pop, including pop while full.
REQ-026 SHALL sustain one accepted read per cycle indefinitely while rsp_ready is held high.
REQ-027 SHALL never push into a full FIFO; credit rule REQ-018 guarantees this, and an assertion SHALL check it.
REQ-028 SHALL order a write followed by a read to the same address so the read returns the written data, since RAM processes requests in issue order.

Reset
REQ-029 SHALL, while reset is high, force req_ready=0, mem_en=0, mem_we=0, and clear the shift register, FIFO pointers and count.
REQ-030 SHALL drive rsp_valid=0 in the cycle after reset is sampled, including mid-burst; in-flight reads are discarded.
REQ-031 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place FIFO_DEPTH derivation, the byte-mask width expression and the RD_LATENCY range check in shared package mem_pkg.
REQ-033 SHALL implement the response buffer as sub-module mem_sp_rsp_fifo (synchronous, registered storage, parameter depth/width).
REQ-034 SHALL connect mem_* ports one-to-one to the single-port RAM wrapper with no glue logic.

Verification
REQ-035 SHALL test: write 0xA5A5...A5 addr 3 full mask, then read addr 3 -> rsp_rdata 0xA5A5...A5, rsp_valid RD_LATENCY+1 cycles after accept.
REQ-036 SHALL test: addr 5 zeroed, write req_we=0x0001 data all-0xFF, read addr 5 -> rsp_rdata 0x00...00FF.
REQ-037 SHALL test: 16 back-to-back reads addr 0..15 with rsp_ready=1 -> req_ready never low, 16 in-order responses, no gaps.
REQ-038 SHALL test: rsp_ready=0, continuous reads -> exactly FIFO_DEPTH accepted then req_ready=0; rsp_ready=1 -> all returned in order, req_ready recovers.
REQ-039 SHALL test: reset asserted with 3 reads in flight -> rsp_valid=0 next cycle, no stale response after release, req_ready=1 first post-reset cycle.
REQ-040 SHALL test: writes interleaved with reads -> response count equals read count only.
